// File: rtl/mvm_pkg.sv
// Shared types and helpers for the streaming matrix-vector multiplier.
package mvm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_M,
      LOAD_V,
      COMPUTE,
      DRAIN
   } state_t;

   // Default accumulator width: a full B x B product plus log2(K) growth bits.
   function automatic int unsigned default_accw(input int unsigned b, input int unsigned k);
      return 2 * b + $clog2(k);
   endfunction

   // Post-process a row result: optional ReLU, then optional clamp to a signed
   // outw-bit range. Without saturation the caller keeps the low outw bits.
   function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] value,
                                                      input int unsigned        outw,
                                                      input logic               sat,
                                                      input logic               relu);
      logic signed [63:0] v;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      v  = value;
      hi = (64'sd1 <<< (outw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (relu && (v < 0)) begin
         v = '0;
      end
      if (sat) begin
         if (v > hi) begin
            v = hi;
         end else if (v < lo) begin
            v = lo;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/mvm_stream_param_mac.sv
// P signed multipliers feeding one adder tree, result registered (pipeline stage 1).
module mvm_mac_lane_tree
   import mvm_pkg::*;
#(
   parameter int unsigned P    = 1,
   parameter int unsigned B    = 8,
   parameter int unsigned ACCW = 19
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic [P*B-1:0]         a,
   input  logic [P*B-1:0]         x,
   output logic signed [ACCW-1:0] sum
);

   logic signed [ACCW-1:0] tree;

   // Sum of the P lane products, each sign-extended to the accumulator width.
   always_comb begin
      tree = '0;
      for (int unsigned j = 0; j < P; j++) begin
         tree = tree + ACCW'($signed(a[j*B +: B]) * $signed(x[j*B +: B]));
      end
   end

   // Register the tree output whenever a column group is issued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum <= '0;
      end else if (en) begin
         sum <= tree;
      end
   end

endmodule

// File: rtl/mvm_stream_param.sv
// Streaming KxK signed matrix-vector multiplier with P MAC lanes, persistent
// matrix/vector storage, post-processing and a valid/ready result stream.
module mvm_stream_param
   import mvm_pkg::*;
#(
   parameter int unsigned K    = 8,
   parameter int unsigned B    = 8,
   parameter int unsigned P    = 1,
   parameter int unsigned ACCW = default_accw(B, K),
   parameter int unsigned OUTW = ACCW,
   parameter int unsigned SAT  = 1,
   parameter int unsigned RELU = 0
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_matrix,
   input  logic                   load_vector,
   input  logic                   in_valid,
   input  logic signed [B-1:0]    data_in,
   input  logic                   start,
   output logic                   busy,
   output logic                   err,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [OUTW-1:0] data_out,
   output logic                   done
);

   localparam int unsigned NW  = K * K;
   localparam int unsigned NG  = NW / P;
   localparam int unsigned MIW = $clog2(NW);
   localparam int unsigned VIW = $clog2(K);
   localparam int unsigned CW  = $clog2(NG + 2) + 1;

   state_t                 state;
   state_t                 state_n;
   logic                   err_n;
   logic                   go_m;
   logic                   go_v;
   logic                   go_run;
   logic                   cmd;
   logic                   issue;
   logic                   last_m;
   logic                   last_v;
   logic                   last_grp;
   logic                   last_y;
   logic [MIW-1:0]         laddr;
   logic [MIW-1:0]         mptr;
   logic [VIW-1:0]         vptr;
   logic [VIW-1:0]         row;
   logic [VIW-1:0]         idx;
   logic [VIW-1:0]         s1_row;
   logic [CW-1:0]          cnt;
   logic                   m_loaded;
   logic                   v_loaded;
   logic                   s1_valid;
   logic                   s1_first;
   logic                   s1_last;
   logic signed [ACCW-1:0] lane_sum;
   logic signed [ACCW-1:0] acc;
   logic signed [ACCW-1:0] acc_next;
   logic signed [OUTW-1:0] y_val;
   logic [P*B-1:0]         a_flat;
   logic [P*B-1:0]         x_flat;

   logic signed [B-1:0]    mat [NW];
   logic signed [B-1:0]    vec [K];
   logic signed [OUTW-1:0] yb  [K];

   assign cmd      = load_matrix | load_vector | start;
   assign last_m   = (laddr == MIW'(NW - 1));
   assign last_v   = (laddr == MIW'(K - 1));
   assign last_grp = (vptr == VIW'(K - P));
   assign last_y   = (idx == VIW'(K - 1));
   assign issue    = (state == COMPUTE) && (cnt < CW'(NG));

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state, command acceptance and rejected-command detection.
   always_comb begin
      state_n = state;
      err_n   = 1'b0;
      go_m    = 1'b0;
      go_v    = 1'b0;
      go_run  = 1'b0;
      case (state)
         IDLE: begin
            if (load_matrix) begin
               go_m    = 1'b1;
               state_n = LOAD_M;
               err_n   = load_vector | start;
            end else if (load_vector) begin
               go_v    = 1'b1;
               state_n = LOAD_V;
               err_n   = start;
            end else if (start) begin
               if (m_loaded && v_loaded) begin
                  go_run  = 1'b1;
                  state_n = COMPUTE;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         LOAD_M: begin
            err_n = cmd;
            if (in_valid && last_m) begin
               state_n = IDLE;
            end
         end
         LOAD_V: begin
            err_n = cmd;
            if (in_valid && last_v) begin
               state_n = IDLE;
            end
         end
         COMPUTE: begin
            err_n = cmd;
            // Issue cycles plus the two pipeline stages must have drained.
            if (cnt == CW'(NG + 1)) begin
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            err_n = cmd;
            if (out_ready && last_y) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Error pulse register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else begin
         err <= err_n;
      end
   end

   // Operand selection for the current column group.
   always_comb begin
      a_flat = '0;
      x_flat = '0;
      for (int unsigned j = 0; j < P; j++) begin
         a_flat[j*B +: B] = mat[mptr + MIW'(j)];
         x_flat[j*B +: B] = vec[vptr + VIW'(j)];
      end
   end

   mvm_mac_lane_tree #(
      .P    (P),
      .B    (B),
      .ACCW (ACCW)
   ) u_tree (
      .clk   (clk),
      .reset (reset),
      .en    (issue),
      .a     (a_flat),
      .x     (x_flat),
      .sum   (lane_sum)
   );

   // Stage 2 accumulation value and the post-processed row result.
   always_comb begin
      acc_next = s1_first ? lane_sum : (acc + lane_sum);
      y_val    = OUTW'(sat_narrow(64'(acc_next), OUTW, (SAT != 0), (RELU != 0)));
   end

   // Counters, load flags, issue pointers and pipeline sideband.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         laddr    <= '0;
         mptr     <= '0;
         vptr     <= '0;
         row      <= '0;
         idx      <= '0;
         cnt      <= '0;
         m_loaded <= 1'b0;
         v_loaded <= 1'b0;
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_row   <= '0;
         acc      <= '0;
      end else begin
         if (go_m) begin
            laddr    <= '0;
            m_loaded <= 1'b0;
         end
         if (go_v) begin
            laddr    <= '0;
            v_loaded <= 1'b0;
         end
         if ((state == LOAD_M) && in_valid) begin
            laddr <= laddr + 1'b1;
            if (last_m) begin
               m_loaded <= 1'b1;
            end
         end
         if ((state == LOAD_V) && in_valid) begin
            laddr <= laddr + 1'b1;
            if (last_v) begin
               v_loaded <= 1'b1;
            end
         end
         if (go_run) begin
            cnt  <= '0;
            mptr <= '0;
            vptr <= '0;
            row  <= '0;
            idx  <= '0;
         end
         if (state == COMPUTE) begin
            cnt <= cnt + 1'b1;
         end
         if (issue) begin
            mptr <= mptr + MIW'(P);
            if (last_grp) begin
               vptr <= '0;
               row  <= row + 1'b1;
            end else begin
               vptr <= vptr + VIW'(P);
            end
         end
         s1_valid <= issue;
         s1_first <= (vptr == '0);
         s1_last  <= last_grp;
         s1_row   <= row;
         if (s1_valid) begin
            acc <= acc_next;
         end
         if ((state == DRAIN) && out_ready) begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Matrix, vector and result storage; contents persist across runs.
   always_ff @(posedge clk) begin
      if ((state == LOAD_M) && in_valid) begin
         mat[laddr] <= data_in;
      end
      if ((state == LOAD_V) && in_valid) begin
         vec[laddr[VIW-1:0]] <= data_in;
      end
      if (s1_valid && s1_last) begin
         yb[s1_row] <= y_val;
      end
   end

   // Status and result stream outputs, all decoded from the state register.
   always_comb begin
      busy      = (state != IDLE);
      out_valid = (state == DRAIN);
      data_out  = out_valid ? yb[idx] : '0;
      done      = out_valid && out_ready && last_y;
   end

endmodule

// File: tb/tb_mvm_stream_param.sv
// Randomized self-checking bench: three configurations share one stimulus stream.
module tb_mvm_stream_param;

   localparam int K    = 4;
   localparam int B    = 8;
   localparam int P    = 2;
   localparam int ACCW = 2 * B + $clog2(K);
   localparam int OW   = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic load_matrix = 1'b0;
   logic load_vector = 1'b0;
   logic in_valid = 1'b0;
   logic start = 1'b0;
   logic out_ready = 1'b0;
   logic signed [B-1:0] data_in = '0;

   wire [2:0] busy_v;
   wire [2:0] err_v;
   wire [2:0] ov_v;
   wire [2:0] done_v;
   wire signed [ACCW-1:0] dout_a;
   wire signed [OW-1:0]   dout_b;
   wire signed [OW-1:0]   dout_c;

   int total = 0;
   int passed = 0;
   int a_m [K*K];
   int x_v [K];

   always #5 clk = ~clk;

   mvm_stream_param #(.K(K), .B(B), .P(P), .OUTW(ACCW), .SAT(1), .RELU(0)) dut_a (
      .clk(clk), .reset(reset), .load_matrix(load_matrix), .load_vector(load_vector),
      .in_valid(in_valid), .data_in(data_in), .start(start), .busy(busy_v[0]),
      .err(err_v[0]), .out_valid(ov_v[0]), .out_ready(out_ready), .data_out(dout_a),
      .done(done_v[0]));

   mvm_stream_param #(.K(K), .B(B), .P(P), .OUTW(OW), .SAT(1), .RELU(0)) dut_b (
      .clk(clk), .reset(reset), .load_matrix(load_matrix), .load_vector(load_vector),
      .in_valid(in_valid), .data_in(data_in), .start(start), .busy(busy_v[1]),
      .err(err_v[1]), .out_valid(ov_v[1]), .out_ready(out_ready), .data_out(dout_b),
      .done(done_v[1]));

   mvm_stream_param #(.K(K), .B(B), .P(P), .OUTW(OW), .SAT(0), .RELU(1)) dut_c (
      .clk(clk), .reset(reset), .load_matrix(load_matrix), .load_vector(load_vector),
      .in_valid(in_valid), .data_in(data_in), .start(start), .busy(busy_v[2]),
      .err(err_v[2]), .out_valid(ov_v[2]), .out_ready(out_ready), .data_out(dout_c),
      .done(done_v[2]));

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      total++;
      if (got !== exp) begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         passed++;
      end
   endtask

   // Reference: plain dot product, then ReLU / clamp / modular wrap to outw bits.
   function automatic longint model_y(input int r, input int outw, input bit sat, input bit relu);
      longint s;
      longint span;
      longint hi;
      s = 0;
      for (int j = 0; j < K; j++) begin
         s += longint'(a_m[r*K + j]) * longint'(x_v[j]);
      end
      if (relu && s < 0) s = 0;
      span = longint'(1) << outw;
      hi   = span / 2 - 1;
      if (sat) begin
         if (s > hi) s = hi;
         if (s < -(span / 2)) s = -(span / 2);
      end else begin
         s = s % span;
         if (s < 0) s += span;
         if (s > hi) s -= span;
      end
      return s;
   endfunction

   function automatic int rnd_elem();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   task automatic load_mat(input bit gaps, input bit poke, input bit both);
      int w;
      bit poked;
      w = 0;
      poked = 1'b0;
      @(negedge clk);
      load_matrix = 1'b1;
      load_vector = both;
      @(negedge clk);
      load_matrix = 1'b0;
      load_vector = 1'b0;
      if (both) begin
         chk("err_both_loads", err_v, 3'b111);
         chk("busy_both_loads", busy_v, 3'b111);
      end
      while (w < K*K) begin
         if (start) begin
            start = 1'b0;
            chk("err_start_in_load", err_v, 3'b111);
         end
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            data_in  = a_m[w][B-1:0];
            w++;
         end
         if (poke && !poked && w == 6) begin
            start = 1'b1;
            poked = 1'b1;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk("idle_after_mload", busy_v, 3'b000);
   endtask

   task automatic load_vec(input bit gaps);
      int w;
      w = 0;
      @(negedge clk);
      load_vector = 1'b1;
      @(negedge clk);
      load_vector = 1'b0;
      while (w < K) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            data_in  = x_v[w][B-1:0];
            w++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("idle_after_vload", busy_v, 3'b000);
   endtask

   // mode 0: always ready; 1: stall 3 cycles while y[1] is presented; 2: random ready.
   task automatic run(input int mode);
      longint ea [K];
      longint eb [K];
      longint ec [K];
      int lat;
      int idx;
      int stall;
      int cyc;
      int dones;
      bit r;
      for (int i = 0; i < K; i++) begin
         ea[i] = model_y(i, ACCW, 1'b1, 1'b0);
         eb[i] = model_y(i, OW, 1'b1, 1'b0);
         ec[i] = model_y(i, OW, 1'b0, 1'b1);
      end
      @(negedge clk);
      start = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      chk("busy_after_start", busy_v, 3'b111);
      chk("no_err_on_start", err_v, 3'b000);
      lat = 0;
      while (ov_v[0] !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("latency", lat, K*K/P + 2);
      idx = 0;
      stall = 0;
      cyc = 0;
      dones = 0;
      while (idx < K && cyc < 200) begin
         case (mode)
            0: r = 1'b1;
            1: r = !(idx == 1 && stall < 3);
            default: r = ($urandom_range(0, 2) != 0);
         endcase
         if (!r && idx == 1) stall++;
         out_ready = r;
         #1;
         chk("out_valid", ov_v, 3'b111);
         chk("y_sat18", dout_a, ea[idx]);
         chk("y_sat16", dout_b, eb[idx]);
         chk("y_trunc16_relu", dout_c, ec[idx]);
         if (done_v[0] === 1'b1) dones++;
         if (r) begin
            chk("done_on_accept", done_v, (idx == K-1) ? 3'b111 : 3'b000);
            idx++;
         end else begin
            chk("done_while_stalled", done_v, 3'b000);
         end
         @(posedge clk);
         #1 cyc++;
      end
      out_ready = 1'b0;
      chk("all_results_accepted", idx, K);
      chk("done_count", dones, 1);
      chk("busy_after_drain", busy_v, 3'b000);
      chk("valid_after_drain", ov_v, 3'b000);
      chk("done_after_drain", done_v, 3'b000);
      if (mode == 1) chk("stall_cycles", stall, 3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy_v, 3'b000);
      chk("rst_err", err_v, 3'b000);
      chk("rst_valid", ov_v, 3'b000);
      chk("rst_done", done_v, 3'b000);
      chk("rst_dout_a", dout_a, 0);
      chk("rst_dout_c", dout_c, 0);
      reset = 1'b1;

      // start with nothing loaded
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("err_start_unloaded", err_v, 3'b111);
      chk("busy_start_unloaded", busy_v, 3'b000);
      @(posedge clk);
      #1 chk("err_one_cycle", err_v, 3'b000);

      // identity matrix
      for (int i = 0; i < K*K; i++) a_m[i] = (i / K == i % K) ? 1 : 0;
      for (int i = 0; i < K; i++) x_v[i] = i + 1;
      load_mat(1'b0, 1'b0, 1'b0);
      load_vec(1'b0);
      run(0);

      // extreme negative operands
      for (int i = 0; i < K*K; i++) a_m[i] = -128;
      for (int i = 0; i < K; i++) x_v[i] = -128;
      load_mat(1'b1, 1'b0, 1'b0);
      load_vec(1'b1);
      run(0);

      // negative row for ReLU, start poked during the matrix load
      for (int i = 0; i < K*K; i++) a_m[i] = rnd_elem();
      a_m[0] = -1; a_m[1] = 0; a_m[2] = 0; a_m[3] = 0;
      x_v[0] = 5; x_v[1] = 1; x_v[2] = 1; x_v[3] = 1;
      load_mat(1'b1, 1'b1, 1'b0);
      load_vec(1'b0);
      run(0);

      // backpressure on y[1]
      for (int i = 0; i < K*K; i++) a_m[i] = rnd_elem();
      for (int i = 0; i < K; i++) x_v[i] = rnd_elem();
      load_mat(1'b1, 1'b0, 1'b0);
      load_vec(1'b1);
      run(1);

      // matrix reuse with only a vector reload
      for (int i = 0; i < K; i++) x_v[i] = 2;
      load_vec(1'b1);
      run(0);

      // simultaneous load commands: matrix load wins, vector kept
      for (int i = 0; i < K*K; i++) a_m[i] = rnd_elem();
      load_mat(1'b1, 1'b0, 1'b1);
      run(2);

      // random runs
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < K*K; i++) a_m[i] = rnd_elem();
         for (int i = 0; i < K; i++) x_v[i] = rnd_elem();
         load_mat(1'b1, 1'b0, 1'b0);
         load_vec(1'b1);
         run(2);
      end

      // asynchronous reset in the middle of a computation
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("async_rst_busy", busy_v, 3'b000);
      chk("async_rst_valid", ov_v, 3'b000);
      chk("async_rst_done", done_v, 3'b000);
      chk("async_rst_err", err_v, 3'b000);
      chk("async_rst_dout_b", dout_b, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("err_start_after_rst", err_v, 3'b111);
      chk("busy_start_after_rst", busy_v, 3'b000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mvm_stream_param.md
Name: mvm_stream_param

Overview:
- Parametrised successor to the fixed 8x8 matrix-vector multiplier: computes y = A·x for a KxK signed matrix, with P parallel MAC lanes.
- Matrix and vector are loaded serially over one data port.
- Results stream out over a valid/ready handshake.
- New over the fixed block: the matrix is retained across runs, output backpressure, optional saturation and ReLU, and an error flag for illegal start.

Parameters:
K, 8, matrix dimension and vector length (K>=2)
B, 8, signed input element width
P, 1, parallel MAC lanes; must divide K
ACCW, 2*B+$clog2(K), internal accumulator width
OUTW, ACCW, output width (OUTW<=ACCW)
SAT, 1, 1 = saturate to OUTW on narrowing; 0 = truncate (keep low OUTW bits)
RELU, 0, 1 = clamp negative results to 0 before narrowing

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
load_matrix  in  1  one-cycle pulse: begin matrix load (K*K words follow)
load_vector  in  1  one-cycle pulse: begin vector load (K words follow)
in_valid  in  1  qualifies data_in during a load
data_in  in  B  signed element; matrix in row-major order, a[r][c] is word r*K+c
start  in  1  one-cycle pulse: begin computation
busy  out  1  high outside IDLE
err  out  1  one-cycle pulse on a rejected command
out_valid  out  1  data_out holds a result
out_ready  in  1  consumer accepts data_out
data_out  out  OUTW  signed result y[i], emitted in order i=0..K-1
done  out  1  one-cycle pulse on the cycle the last result is accepted

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, err=0, out_valid=0, data_out=0, done=0; counters cleared; m_loaded=0, v_loaded=0. Reset asserted mid-operation aborts immediately; partial results are discarded.
- FSM states: IDLE, LOAD_M, LOAD_V, COMPUTE, DRAIN.
- IDLE -> LOAD_M on load_matrix. IDLE -> LOAD_V on load_vector. If both arrive in the same cycle: LOAD_M is taken, err pulses.
- LOAD_M: writes a word each cycle in_valid=1, address counter 0..K*K-1. After the last word: m_loaded=1, return to IDLE. in_valid gaps are permitted. load_* or start during a load: ignored, err pulses.
- LOAD_V: same rules, K words; sets v_loaded=1.
- A new load_matrix clears m_loaded until that load completes. Likewise load_vector and v_loaded.
- start in IDLE with m_loaded & v_loaded -> COMPUTE. Otherwise: err pulses, state stays IDLE.
- COMPUTE: row r, column group g (P columns per cycle). P signed B x B products feed an adder tree, registered as stage 1. Stage 2 accumulates into an ACCW accumulator. Row result is written to the result buffer y[r] after its last group. Total: K*K/P cycles plus 2 pipeline cycles, then -> DRAIN.
- Post-processing when writing y[r]:
  - RELU=1 and value<0 -> 0.
  - SAT=1: clamp to [-2^(OUTW-1), 2^(OUTW-1)-1].
  - SAT=0: keep the low OUTW bits.
- DRAIN: out_valid=1 with data_out=y[i]. i advances only on out_valid & out_ready. While out_ready=0, data_out is held stable. On acceptance of y[K-1]: done=1 for one cycle, out_valid=0, -> IDLE.
- Commands in COMPUTE or DRAIN are ignored and err pulses.
- Matrix and vector storage persist after a run. A new start may reuse the matrix after only a vector reload.
- Accumulation never overflows at the default ACCW.

Decomposition:
- Package mvm_pkg: state enum typedef; function clog2-based default widths; function sat_narrow(value, OUTW, SAT, RELU).
- One sub-module: mvm_mac_lane_tree (P multipliers + registered adder tree, parameters P, B, ACCW).
- Storage arrays and the FSM live in the top module.

Test Plan:
1. K=4, B=8, P=2: load identity matrix, x=[1,2,3,4], start, out_ready=1 -> data_out 1,2,3,4; done on the 4th acceptance; latency 4*4/2+2=10 cycles from start to first out_valid.
2. K=4, all a=-128, all x=-128 (ACCW=18) -> each y=65536. With OUTW=16, SAT=1 -> each y=32767. With SAT=0 -> each y=0.
3. RELU=1, a row=[-1,0,0,0], x=[5,1,1,1] -> y[0]=0; other rows unaffected.
4. Backpressure: out_ready low for 3 cycles during y[1] -> data_out holds y[1] stable, no skip or duplicate, done asserted once.
5. Matrix reuse: after run 1, reload only x=[2,2,2,2], start -> y = A·x with the old A. start immediately after reset -> err pulse, busy stays 0.
6. Reset pulled low 3 cycles into COMPUTE -> all outputs 0 within the same cycle (async). A following start without reloading -> err pulse.
